video_mem_port: RTL and testbench

Controller that drives the 256-deep, 1-bit shift-register video memory (`fifo_1bit_256depth`) from the outside. It reads one cell per scan step for the VGA pixel path and recirculates every bit so memory contents persist across frames. It merges single-bit game-logic writes into the recirculating stream at the correct address. During blanking it spins the memory back to address 0, so every frame starts aligned.

---
 rtl/video_mem_port_if.sv | 34 +++
 rtl/video_mem_port.sv | 110 +++++++++++
 tb/tb_video_mem_port.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_mem_port_if.sv
// Handshake and memory-side bundle for video_mem_port.
// master: scan/write client plus FIFO head bit; slave: the controller.
interface video_mem_port_if #(
   parameter int ADDR_W = 8
);
   logic              scan_active;
   logic              scan_step;
   logic              pix_bit;
   logic              pix_valid;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data;
   logic              wr_ack;
   logic [ADDR_W-1:0] head;
   logic              aligned;
   logic              align_err;
   logic              fifo_enable;
   logic              fifo_data_in;
   logic              fifo_data_out;

   modport master (
      output scan_active, scan_step, wr_req, wr_addr, wr_data,
      output fifo_data_out,
      input  pix_bit, pix_valid, wr_ack, head, aligned, align_err,
      input  fifo_enable, fifo_data_in
   );

   modport slave (
      input  scan_active, scan_step, wr_req, wr_addr, wr_data,
      input  fifo_data_out,
      output pix_bit, pix_valid, wr_ack, head, aligned, align_err,
      output fifo_enable, fifo_data_in
   );
endinterface

// File: rtl/video_mem_port.sv
// Drives a 1-bit shift-register video memory: scan reads, merged writes,
// recirculation and blanking-time realignment to address 0.
// Ports: clk, rst (sync, active-high), bus (video_mem_port_if.slave).
module video_mem_port #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   video_mem_port_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, SCAN, SPIN} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] head;
   logic              pix_bit;
   logic              pix_valid;
   logic              wr_ack;
   logic              aligned;
   logic              align_err;

   logic shift;
   logic wr_pend;
   logic hit;
   logic din;

   // The request is still visible during its own ack cycle; it only
   // counts as a new request from the following cycle.
   always_comb begin
      wr_pend = bus.wr_req && !wr_ack;
      shift   = 1'b0;
      if (!rst) begin
         case (state)
            SCAN:    shift = bus.scan_active && bus.scan_step;
            SPIN:    shift = !bus.scan_active;
            default: shift = 1'b0;
         endcase
      end
      hit = shift && wr_pend && (bus.wr_addr == head);
      din = 1'b0;
      if (shift) din = hit ? bus.wr_data : bus.fifo_data_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         head      <= '0;
         pix_bit   <= 1'b0;
         pix_valid <= 1'b0;
         wr_ack    <= 1'b0;
         aligned   <= 1'b1;
         align_err <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         wr_ack    <= hit;
         if (shift) head <= head + 1'b1;
         case (state)
            IDLE: begin
               if (bus.scan_active) begin
                  state   <= SCAN;
                  aligned <= 1'b0;
               end else if (wr_pend) begin
                  state   <= SPIN;
                  aligned <= 1'b0;
               end
            end
            SCAN: begin
               if (shift) begin
                  pix_bit   <= din;
                  pix_valid <= 1'b1;
               end
               if (!bus.scan_active) begin
                  if (head != '0 || wr_pend) begin
                     state <= SPIN;
                  end else begin
                     state   <= IDLE;
                     aligned <= 1'b1;
                  end
               end
            end
            SPIN: begin
               if (bus.scan_active) begin
                  // Blanking too short: resume scanning wherever head is.
                  state     <= SCAN;
                  align_err <= 1'b1;
               end else if (head == LAST && !(wr_pend && !hit)) begin
                  // This shift lands head on 0 with nothing left to merge.
                  state   <= IDLE;
                  aligned <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               aligned <= 1'b1;
            end
         endcase
      end
   end

   assign bus.head         = head;
   assign bus.pix_bit      = pix_bit;
   assign bus.pix_valid    = pix_valid;
   assign bus.wr_ack       = wr_ack;
   assign bus.aligned      = aligned;
   assign bus.align_err    = align_err;
   assign bus.fifo_enable  = shift;
   assign bus.fifo_data_in = din;
endmodule

// File: tb/tb_video_mem_port.sv
// Bench for video_mem_port with a behavioural 256-bit shift-register memory.
// Directed scenarios, each task doing its own inline comparisons.
module tb_video_mem_port;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_mem [256];
   logic [255:0] mem;

   always #5 clk = ~clk;

   video_mem_port_if #(.ADDR_W(8)) bus ();

   video_mem_port #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // mem[0] is the head cell; enable shifts data_in into the tail.
   always @(posedge clk)
      if (bus.fifo_enable) mem <= {bus.fifo_data_in, mem[255:1]};
   assign bus.fifo_data_out = mem[0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (bus.aligned) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic end_frame(output bit ok);
      bus.scan_step   = 1'b0;
      bus.scan_active = 1'b0;
      tick();
      wait_idle(600, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.scan_active = 1'b0;
      bus.scan_step   = 1'b0;
      bus.wr_req      = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.head !== 8'd0 || bus.aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_head: head=%0d aligned=%0b, need 0/1",
                  bus.head, bus.aligned);
      end
      n_checks++;
      if ({bus.pix_bit, bus.pix_valid, bus.wr_ack, bus.align_err}
          !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outs: pix=%0b pv=%0b ack=%0b err=%0b, need 0",
                  bus.pix_bit, bus.pix_valid, bus.wr_ack, bus.align_err);
      end
      n_checks++;
      if ({bus.fifo_enable, bus.fifo_data_in} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_fifo: en=%0b din=%0b, need 0/0",
                  bus.fifo_enable, bus.fifo_data_in);
      end
      rst = 1'b0;
      bus.scan_step = 1'b1;
      #1;
      n_checks++;
      if (bus.fifo_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL step_blank_en: en=%0b, need 0", bus.fifo_enable);
      end
      tick();
      n_checks++;
      if (bus.pix_valid !== 1'b0 || bus.head !== 8'd0) begin
         n_fail++;
         $display("FAIL step_blank_pv: pv=%0b head=%0d, need 0/0",
                  bus.pix_valid, bus.head);
      end
      bus.scan_step = 1'b0;
   endtask

   task automatic test_preload();
      int  k;
      bit  got;
      bit  ok;
      for (int idx = 0; idx < 256; idx++) begin
         k = (idx < 128) ? idx * 2 : (idx - 128) * 2 + 1;
         bus.wr_addr = 8'(k);
         bus.wr_data = k[0];
         bus.wr_req  = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 600; c++) begin
            tick();
            if (bus.wr_ack) begin
               got = 1'b1;
               break;
            end
         end
         n_checks++;
         if (!got) begin
            n_fail++;
            $display("FAIL preload_ack: addr=%0d ack=0, need 1", k);
         end
         exp_mem[k] = k[0];
      end
      bus.wr_req = 1'b0;
      wait_idle(600, ok);
      n_checks++;
      if (!ok || bus.head !== 8'd0) begin
         n_fail++;
         $display("FAIL preload_idle: aligned=%0b head=%0d, need 1/0",
                  bus.aligned, bus.head);
      end
   endtask

   task automatic test_full_scan();
      int bad = 0;
      bus.scan_active = 1'b1;
      tick();
      n_checks++;
      if (bus.aligned !== 1'b0) begin
         n_fail++;
         $display("FAIL scan_aligned: aligned=%0b, need 0", bus.aligned);
      end
      bus.scan_step = 1'b1;
      for (int k = 0; k < 256; k++) begin
         tick();
         if (bus.pix_valid !== 1'b1 || bus.pix_bit !== exp_mem[k]) begin
            bad++;
            if (bad < 4)
               $display("FAIL full_scan_pix: cell %0d pv=%0b pix=%0b, need 1/%0b",
                        k, bus.pix_valid, bus.pix_bit, exp_mem[k]);
         end
      end
      n_checks++;
      if (bad != 0) n_fail++;
      bus.scan_step = 1'b0;
      n_checks++;
      if (bus.head !== 8'd0) begin
         n_fail++;
         $display("FAIL full_scan_head: head=%0d, need 0", bus.head);
      end
      bus.scan_active = 1'b0;
      tick();
      n_checks++;
      if (bus.aligned !== 1'b1 || bus.fifo_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL full_scan_idle: aligned=%0b en=%0b, need 1/0",
                  bus.aligned, bus.fifo_enable);
      end
   endtask

   task automatic test_partial_spin();
      int cnt = 0;
      bit ok;
      bus.scan_active = 1'b1;
      tick();
      bus.scan_step = 1'b1;
      repeat (100) tick();
      bus.scan_step   = 1'b0;
      bus.scan_active = 1'b0;
      tick();
      for (int c = 0; c < 400; c++) begin
         if (bus.aligned) break;
         if (bus.fifo_enable) cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 156 || bus.head !== 8'd0 || bus.aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL spin_count: spins=%0d head=%0d al=%0b, need 156/0/1",
                  cnt, bus.head, bus.aligned);
      end
      bus.scan_active = 1'b1;
      tick();
      bus.scan_step = 1'b1;
      tick();
      n_checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_bit !== exp_mem[0]) begin
         n_fail++;
         $display("FAIL frame_first_pix: pv=%0b pix=%0b, need 1/%0b",
                  bus.pix_valid, bus.pix_bit, exp_mem[0]);
      end
      end_frame(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL spin_frame_end: aligned=%0b, need 1", bus.aligned);
      end
   endtask

   task automatic test_idle_write();
      int ack_at = -1;
      int cnt = 0;
      bit ok;
      bus.wr_addr = 8'd5;
      bus.wr_data = 1'b1;
      bus.wr_req  = 1'b1;
      tick();
      for (int c = 0; c < 400; c++) begin
         if (bus.wr_ack) begin
            if (ack_at < 0) ack_at = c;
            bus.wr_req = 1'b0;
         end
         if (bus.aligned) break;
         if (bus.fifo_enable) cnt++;
         tick();
      end
      exp_mem[5] = 1'b1;
      n_checks++;
      if (ack_at != 6) begin
         n_fail++;
         $display("FAIL idle_write_ack: ack at %0d, need 6", ack_at);
      end
      n_checks++;
      if (cnt != 256 || bus.aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_write_spin: spins=%0d al=%0b, need 256/1",
                  cnt, bus.aligned);
      end
      bus.wr_req = 1'b0;
      bus.scan_active = 1'b1;
      tick();
      bus.scan_step = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k >= 4) begin
            n_checks++;
            if (bus.pix_bit !== exp_mem[k]) begin
               n_fail++;
               $display("FAIL idle_write_read: cell %0d pix=%0b, need %0b",
                        k, bus.pix_bit, exp_mem[k]);
            end
         end
      end
      end_frame(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL idle_write_end: aligned=%0b, need 1", bus.aligned);
      end
   endtask

   task automatic test_scan_write();
      bit ok;
      bus.scan_active = 1'b1;
      tick();
      bus.scan_step = 1'b1;
      repeat (10) tick();
      n_checks++;
      if (bus.head !== 8'd10) begin
         n_fail++;
         $display("FAIL scan_write_head: head=%0d, need 10", bus.head);
      end
      bus.wr_addr = 8'd10;
      bus.wr_data = 1'b1;
      bus.wr_req  = 1'b1;
      tick();
      n_checks++;
      if ({bus.pix_valid, bus.pix_bit, bus.wr_ack} !== 3'b111) begin
         n_fail++;
         $display("FAIL scan_write_hit: pv=%0b pix=%0b ack=%0b, need 1/1/1",
                  bus.pix_valid, bus.pix_bit, bus.wr_ack);
      end
      bus.wr_req = 1'b0;
      exp_mem[10] = 1'b1;
      tick();
      n_checks++;
      if (bus.wr_ack !== 1'b0 || bus.pix_bit !== exp_mem[11]) begin
         n_fail++;
         $display("FAIL scan_write_next: ack=%0b pix=%0b, need 0/%0b",
                  bus.wr_ack, bus.pix_bit, exp_mem[11]);
      end
      end_frame(ok);
      bus.scan_active = 1'b1;
      tick();
      bus.scan_step = 1'b1;
      repeat (11) tick();
      n_checks++;
      if (!ok || bus.pix_bit !== 1'b1) begin
         n_fail++;
         $display("FAIL scan_write_persist: ok=%0b cell10=%0b, need 1/1",
                  ok, bus.pix_bit);
      end
      end_frame(ok);
   endtask

   task automatic test_align_err();
      int cnt = 0;
      bit ok;
      bus.scan_active = 1'b1;
      tick();
      bus.scan_step = 1'b1;
      repeat (100) tick();
      bus.scan_step   = 1'b0;
      bus.scan_active = 1'b0;
      tick();
      for (int c = 0; c < 40 && cnt < 20; c++) begin
         if (bus.fifo_enable) cnt++;
         tick();
      end
      bus.scan_active = 1'b1;
      #1;
      n_checks++;
      if (bus.fifo_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL align_stop: en=%0b, need 0", bus.fifo_enable);
      end
      tick();
      n_checks++;
      if (bus.align_err !== 1'b1 || bus.head !== 8'd120 ||
          bus.aligned !== 1'b0) begin
         n_fail++;
         $display("FAIL align_err_set: err=%0b head=%0d al=%0b, need 1/120/0",
                  bus.align_err, bus.head, bus.aligned);
      end
      bus.scan_step = 1'b1;
      tick();
      bus.scan_step = 1'b0;
      n_checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_bit !== exp_mem[120]) begin
         n_fail++;
         $display("FAIL align_resume_pix: pv=%0b pix=%0b, need 1/%0b",
                  bus.pix_valid, bus.pix_bit, exp_mem[120]);
      end
      end_frame(ok);
      n_checks++;
      if (!ok || bus.align_err !== 1'b1) begin
         n_fail++;
         $display("FAIL align_err_sticky: ok=%0b err=%0b, need 1/1",
                  ok, bus.align_err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.align_err !== 1'b0 || bus.head !== 8'd0) begin
         n_fail++;
         $display("FAIL align_err_clear: err=%0b head=%0d, need 0/0",
                  bus.align_err, bus.head);
      end
   endtask

   task automatic test_reset_mid_write();
      int acks = 0;
      bus.wr_addr = 8'd200;
      bus.wr_data = 1'b0;
      bus.wr_req  = 1'b1;
      tick();
      repeat (10) tick();
      n_checks++;
      if (bus.fifo_enable !== 1'b1 || bus.head !== 8'd10) begin
         n_fail++;
         $display("FAIL mid_spin: en=%0b head=%0d, need 1/10",
                  bus.fifo_enable, bus.head);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.fifo_enable, bus.fifo_data_in} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_stop_shift: en=%0b din=%0b, need 0/0",
                  bus.fifo_enable, bus.fifo_data_in);
      end
      tick();
      n_checks++;
      if (bus.head !== 8'd0 || bus.aligned !== 1'b1 ||
          {bus.pix_bit, bus.pix_valid, bus.wr_ack, bus.align_err}
          !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mid_outs: head=%0d al=%0b ack=%0b pv=%0b, need 0/1/0/0",
                  bus.head, bus.aligned, bus.wr_ack, bus.pix_valid);
      end
      rst = 1'b0;
      bus.wr_req = 1'b0;
      repeat (3) begin
         tick();
         if (bus.wr_ack) acks++;
      end
      n_checks++;
      if (acks != 0 || bus.aligned !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_no_ack: acks=%0d al=%0b, need 0/1",
                  acks, bus.aligned);
      end
   endtask

   initial begin
      mem = {64{4'b1100}};
      for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
      test_reset();
      test_preload();
      test_full_scan();
      test_partial_spin();
      test_idle_write();
      test_scan_write();
      test_align_err();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
